periph_bus_arbiter: RTL and testbench

PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

---
 rtl/periph_bus_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_periph_bus_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus_arbiter.sv
// Two-master, three-slave peripheral bus arbiter.
// Round-robin arbitration between the core (requester 0) and the preload/debug
// master (requester 1), address decode onto bootrom/UART/PLIC, and a bounded
// wait for the slave acknowledge with an error response on timeout or unmapped
// address. One transaction is in flight at a time.
module periph_bus_arbiter #(
   parameter int unsigned     XLEN          = 32,
   parameter logic [XLEN-1:0] BOOTROM_BASE  = 32'h8000_0000,
   parameter logic [XLEN-1:0] BOOTROM_RANGE = 32'h0000_1000,
   parameter logic [XLEN-1:0] UART_BASE     = 32'h1000_0000,
   parameter logic [XLEN-1:0] UART_RANGE    = 32'h0000_1000,
   parameter logic [XLEN-1:0] PLIC_BASE     = 32'h0C00_0000,
   parameter logic [XLEN-1:0] PLIC_RANGE    = 32'h0000_1000,
   parameter int unsigned     TIMEOUT       = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          m_req,
   input  logic [2*XLEN-1:0]   m_addr,
   input  logic [2*XLEN-1:0]   m_wdata,
   input  logic [1:0]          m_we,
   output logic [1:0]          m_gnt,
   output logic [1:0]          m_rvalid,
   output logic [1:0]          m_err,
   output logic [XLEN-1:0]     m_rdata,
   output logic                s_req,
   output logic [2:0]          s_sel,
   output logic [XLEN-1:0]     s_addr,
   output logic [XLEN-1:0]     s_wdata,
   output logic                s_we,
   input  logic [2:0]          s_ack,
   input  logic [3*XLEN-1:0]   s_rdata
);

   // Timer wide enough to hold TIMEOUT-1 (TIMEOUT is at least 2).
   localparam int unsigned TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   localparam logic [XLEN-1:0] REGION_BASE  [3] = '{BOOTROM_BASE,  UART_BASE,  PLIC_BASE};
   localparam logic [XLEN-1:0] REGION_RANGE [3] = '{BOOTROM_RANGE, UART_RANGE, PLIC_RANGE};

   typedef enum logic [1:0] {IDLE, BUSY, RESP, ERR} state_t;

   state_t            r_state;
   state_t            w_state_next;

   logic              r_last;      // requester granted most recently
   logic              r_winner;    // requester owning the current transaction
   logic [XLEN-1:0]   r_addr;
   logic [XLEN-1:0]   r_wdata;
   logic              r_we;
   logic [2:0]        r_sel;
   logic [TW-1:0]     r_timer;
   logic [XLEN-1:0]   r_rdata;

   logic              w_any_req;
   logic              w_win;
   logic [XLEN-1:0]   w_req_addr;
   logic [XLEN-1:0]   w_req_wdata;
   logic              w_req_we;
   logic [2:0]        w_hit;
   logic [2:0]        w_sel_dec;
   logic              w_ack_hit;
   logic [XLEN-1:0]   w_rdata_sel;
   logic              w_accept;

   assign w_any_req = |m_req;

   // Round-robin pick: on contention the requester not granted last time wins.
   always_comb begin
      w_win = 1'b0;
      if (m_req == 2'b11) begin
         w_win = ~r_last;
      end else if (m_req[1]) begin
         w_win = 1'b1;
      end
   end

   assign w_req_addr  = w_win ? m_addr[2*XLEN-1:XLEN]  : m_addr[XLEN-1:0];
   assign w_req_wdata = w_win ? m_wdata[2*XLEN-1:XLEN] : m_wdata[XLEN-1:0];
   assign w_req_we    = w_win ? m_we[1]                : m_we[0];

   // Region hit: unsigned offset from base must fall below the range.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_region
         assign w_hit[gi] = (w_req_addr >= REGION_BASE[gi]) &&
                            ((w_req_addr - REGION_BASE[gi]) < REGION_RANGE[gi]);
      end
   endgenerate

   // Overlapping regions resolve bootrom first, then UART, then PLIC.
   always_comb begin
      w_sel_dec = 3'b000;
      if (w_hit[0]) begin
         w_sel_dec = 3'b001;
      end else if (w_hit[1]) begin
         w_sel_dec = 3'b010;
      end else if (w_hit[2]) begin
         w_sel_dec = 3'b100;
      end
   end

   // Only the acknowledge of the selected slave counts; its read data is muxed out.
   assign w_ack_hit = |(s_ack & r_sel);

   always_comb begin
      w_rdata_sel = '0;
      for (int i = 0; i < 3; i++) begin
         if (r_sel[i]) begin
            w_rdata_sel = s_rdata[i*XLEN +: XLEN];
         end
      end
   end

   assign w_accept = (r_state == IDLE) && w_any_req;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state and all bus outputs; outputs are zero unless the state drives them.
   always_comb begin
      w_state_next = r_state;
      m_gnt        = 2'b00;
      m_rvalid     = 2'b00;
      m_err        = 2'b00;
      m_rdata      = '0;
      s_req        = 1'b0;
      s_sel        = 3'b000;
      s_addr       = '0;
      s_wdata      = '0;
      s_we         = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any_req) begin
               m_gnt[w_win] = 1'b1;
               // An unmapped address never reaches the slave bus.
               w_state_next = (|w_hit) ? BUSY : ERR;
            end
         end
         BUSY: begin
            s_req   = 1'b1;
            s_sel   = r_sel;
            s_addr  = r_addr;
            s_wdata = r_wdata;
            s_we    = r_we;
            // A valid acknowledge takes priority over an expiring timer.
            if (w_ack_hit) begin
               w_state_next = RESP;
            end else if (r_timer == TIMER_LAST) begin
               w_state_next = ERR;
            end
         end
         RESP: begin
            m_rvalid[r_winner] = 1'b1;
            m_rdata            = r_rdata;
            w_state_next       = IDLE;
         end
         ERR: begin
            m_rvalid[r_winner] = 1'b1;
            m_err[r_winner]    = 1'b1;
            w_state_next       = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Request latch, round-robin pointer, wait timer and read-data capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last   <= 1'b1;
         r_winner <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_we     <= 1'b0;
         r_sel    <= 3'b000;
         r_timer  <= '0;
         r_rdata  <= '0;
      end else begin
         if (w_accept) begin
            r_last   <= w_win;
            r_winner <= w_win;
            r_addr   <= w_req_addr;
            r_wdata  <= w_req_wdata;
            r_we     <= w_req_we;
            r_sel    <= w_sel_dec;
         end
         if (r_state == BUSY) begin
            r_timer <= r_timer + 1'b1;
         end else begin
            r_timer <= '0;
         end
         if ((r_state == BUSY) && w_ack_hit) begin
            r_rdata <= w_rdata_sel;
         end
      end
   end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter: a table of single transactions
// (decode boundaries, stray acks, timeout, unmapped) plus hand-written
// sequences for contention and reset during an access.
module tb_periph_bus_arbiter;

   localparam int TIMEOUT = 16;

   logic          clk;
   logic          rst;
   logic [1:0]    m_req;
   logic [63:0]   m_addr;
   logic [63:0]   m_wdata;
   logic [1:0]    m_we;
   logic [1:0]    m_gnt;
   logic [1:0]    m_rvalid;
   logic [1:0]    m_err;
   logic [31:0]   m_rdata;
   logic          s_req;
   logic [2:0]    s_sel;
   logic [31:0]   s_addr;
   logic [31:0]   s_wdata;
   logic          s_we;
   logic [2:0]    s_ack;
   logic [95:0]   s_rdata;

   int n_vec = 0;
   int n_bad = 0;

   periph_bus_arbiter #(.XLEN(32), .TIMEOUT(TIMEOUT)) dut (
      .clk      (clk),
      .rst      (rst),
      .m_req    (m_req),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_we     (m_we),
      .m_gnt    (m_gnt),
      .m_rvalid (m_rvalid),
      .m_err    (m_err),
      .m_rdata  (m_rdata),
      .s_req    (s_req),
      .s_sel    (s_sel),
      .s_addr   (s_addr),
      .s_wdata  (s_wdata),
      .s_we     (s_we),
      .s_ack    (s_ack),
      .s_rdata  (s_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        req;        // requester index
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      int          ack_delay;  // BUSY cycles before ack; -1 means never ack
      logic [2:0]  stray;      // acks of other slaves held during BUSY
      logic [31:0] rdata;      // data presented by the addressed slave
      logic [2:0]  exp_sel;    // 0 means unmapped
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " m_gnt"},    64'(m_gnt),    64'd0);
      check({tag, " m_rvalid"}, 64'(m_rvalid), 64'd0);
      check({tag, " m_err"},    64'(m_err),    64'd0);
      check({tag, " m_rdata"},  64'(m_rdata),  64'd0);
      check({tag, " s_req"},    64'(s_req),    64'd0);
      check({tag, " s_sel"},    64'(s_sel),    64'd0);
      check({tag, " s_we"},     64'(s_we),     64'd0);
      check({tag, " s_addr"},   64'(s_addr),   64'd0);
      check({tag, " s_wdata"},  64'(s_wdata),  64'd0);
   endtask

   // One transaction: grant in cycle 0, BUSY from cycle 1 (if mapped), then response.
   task automatic run_vec(input int idx, input vec_t v);
      logic [1:0] rbit;
      int         nbusy;
      rbit = v.req ? 2'b10 : 2'b01;
      s_rdata = {32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
      for (int i = 0; i < 3; i++) begin
         if (v.exp_sel[i]) s_rdata[i*32 +: 32] = v.rdata;
      end
      @(negedge clk);
      m_addr = '0; m_wdata = '0; m_we = '0;
      if (v.req) begin
         m_addr[63:32] = v.addr; m_wdata[63:32] = v.wdata; m_we[1] = v.we;
      end else begin
         m_addr[31:0] = v.addr; m_wdata[31:0] = v.wdata; m_we[0] = v.we;
      end
      m_req = rbit;
      #1;
      check($sformatf("v%0d gnt", idx), 64'(m_gnt), 64'(rbit));
      check($sformatf("v%0d s_req@gnt", idx), 64'(s_req), 64'd0);
      @(negedge clk);
      m_req = 2'b00;
      if (v.exp_sel != 3'b000) begin
         nbusy = (v.ack_delay < 0) ? TIMEOUT : v.ack_delay + 1;
         for (int c = 0; c < nbusy; c++) begin
            s_ack = v.stray | ((v.ack_delay == c) ? v.exp_sel : 3'b000);
            #1;
            check($sformatf("v%0d s_req busy%0d", idx, c), 64'(s_req), 64'd1);
            check($sformatf("v%0d rvalid busy%0d", idx, c), 64'(m_rvalid), 64'd0);
            if (c == 0) begin
               check($sformatf("v%0d s_sel", idx), 64'(s_sel), 64'(v.exp_sel));
               check($sformatf("v%0d s_addr", idx), 64'(s_addr), 64'(v.addr));
               check($sformatf("v%0d s_wdata", idx), 64'(s_wdata), 64'(v.wdata));
               check($sformatf("v%0d s_we", idx), 64'(s_we), 64'(v.we));
            end
            @(negedge clk);
         end
         s_ack = 3'b000;
      end
      #1;
      check($sformatf("v%0d s_req@resp", idx), 64'(s_req), 64'd0);
      check($sformatf("v%0d rvalid", idx), 64'(m_rvalid), 64'(rbit));
      check($sformatf("v%0d err", idx), 64'(m_err), v.exp_err ? 64'(rbit) : 64'd0);
      check($sformatf("v%0d rdata", idx), 64'(m_rdata), 64'(v.exp_rdata));
      @(negedge clk);
      #1;
      check($sformatf("v%0d rvalid after", idx), 64'(m_rvalid), 64'd0);
      $display("vector %0d: req%0d addr=%08h sel=%b err=%0d rdata=%08h",
               idx, v.req, v.addr, s_sel, m_err != 0, m_rdata);
   endtask

   initial begin
      logic [1:0] exp_order [4];
      int         ngr;

      //          req  addr           wdata          we  dly stray   rdata          sel     err  exp_rdata
      vecs[0]  = '{1'b0, 32'h1000_0004, 32'h0000_0000, 1'b0, 2, 3'b000, 32'h0000_00A5, 3'b010, 1'b0, 32'h0000_00A5};
      vecs[1]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 0, 3'b000, 32'h0000_0000, 3'b000, 1'b1, 32'h0000_0000};
      vecs[2]  = '{1'b0, 32'h0C00_0010, 32'h2222_2222, 1'b1, -1, 3'b000, 32'h0000_0000, 3'b100, 1'b1, 32'h0000_0000};
      vecs[3]  = '{1'b1, 32'h0C00_0FFF, 32'h3333_3333, 1'b0, 1, 3'b001, 32'h1234_5678, 3'b100, 1'b0, 32'h1234_5678};
      vecs[4]  = '{1'b0, 32'h0C00_1000, 32'h0000_0000, 1'b0, 0, 3'b000, 32'h0000_0000, 3'b000, 1'b1, 32'h0000_0000};
      vecs[5]  = '{1'b1, 32'h8000_0FFF, 32'hFEED_BEEF, 1'b1, 0, 3'b000, 32'hCAFE_F00D, 3'b001, 1'b0, 32'hCAFE_F00D};
      vecs[6]  = '{1'b0, 32'h8000_1000, 32'h0000_0000, 1'b0, 0, 3'b000, 32'h0000_0000, 3'b000, 1'b1, 32'h0000_0000};
      vecs[7]  = '{1'b1, 32'h1000_0FFF, 32'h4444_4444, 1'b0, 0, 3'b100, 32'h0BAD_F00D, 3'b010, 1'b0, 32'h0BAD_F00D};
      vecs[8]  = '{1'b0, 32'h1000_1000, 32'h0000_0000, 1'b0, 0, 3'b000, 32'h0000_0000, 3'b000, 1'b1, 32'h0000_0000};
      vecs[9]  = '{1'b0, 32'h8000_0000, 32'h5555_5555, 1'b0, 3, 3'b110, 32'h7777_0001, 3'b001, 1'b0, 32'h7777_0001};
      vecs[10] = '{1'b1, 32'h0BFF_FFFF, 32'h0000_0000, 1'b0, 0, 3'b000, 32'h0000_0000, 3'b000, 1'b1, 32'h0000_0000};

      rst = 1'b1; m_req = '0; m_addr = '0; m_wdata = '0; m_we = '0;
      s_ack = '0; s_rdata = '0;
      repeat (3) @(negedge clk);
      #1;
      check_idle_outputs("reset");
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         run_vec(i, vecs[i]);
      end

      // Contention straight after reset: requester 0 first, then alternate.
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
      m_addr  = {32'h1000_0008, 32'h1000_0004};
      s_rdata = {32'h0, 32'h0000_0042, 32'h0};
      s_ack   = 3'b111;
      m_req   = 2'b11;
      ngr     = 0;
      for (int c = 0; c < 30 && ngr < 4; c++) begin
         #1;
         if (m_gnt != 2'b00) begin
            check($sformatf("contention grant %0d", ngr), 64'(m_gnt), 64'(exp_order[ngr]));
            $display("contention grant %0d: m_gnt=%b", ngr, m_gnt);
            ngr++;
         end
         @(negedge clk);
      end
      check("contention grant count", 64'(ngr), 64'd4);
      m_req = 2'b00; s_ack = 3'b000;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;

      // Reset while an access is waiting for its ack.
      m_addr = {32'h0, 32'h1000_0010};
      m_req  = 2'b01;
      #1;
      check("midrst gnt", 64'(m_gnt), 64'd1);
      @(negedge clk); m_req = 2'b00;
      @(negedge clk);
      #1;
      check("midrst busy s_req", 64'(s_req), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check_idle_outputs("midrst");
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         check($sformatf("midrst no rvalid %0d", c), 64'(m_rvalid), 64'd0);
         check($sformatf("midrst no s_req %0d", c), 64'(s_req), 64'd0);
      end
      $display("mid-op reset: access aborted, no response");
      run_vec(11, vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
